seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 100000, SHALL set the clock cycles each digit is scanned (1 kHz per digit at 100 MHz); legal range 4..2^20.
REQ-003 Parameter BLANK_CYC, default 500, SHALL set the anode-off guard cycles at the start of each digit slot; legal range 1..CLK_DIV-2.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 wr_valid  in  1  write request to the shadow digit buffer.
REQ-007 wr_ready  out  1  shadow buffer accepts a write; a write occurs when wr_valid && wr_ready.
REQ-008 wr_addr  in  3  digit index 0..7.
REQ-009 wr_data  in  4  hex value 0..F.
REQ-010 wr_dp  in  1  decimal point for the digit, 1 = lit.
REQ-011 commit  in  1  single-cycle pulse; requests a shadow-to-active copy at the next frame boundary.
REQ-012 digit_en  in  8  per-digit enable; 0 = digit always dark.
REQ-013 an_n  out  8  anode selects, active-low, one-hot-low or all ones.
REQ-014 seg_n  out  8  {dp,g,f,e,d,c,b,a}, active-low.
REQ-015 frame_done  out  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-016 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle it equals CLK_DIV-1.
REQ-017 A 3-bit scan index SHALL increment on tick and wrap from 7 to 0.
REQ-018 The guard counter SHALL load BLANK_CYC on tick and decrement to 0 and hold; anodes SHALL be off while it is nonzero.
REQ-019 Outputs SHALL be registered: an_n/seg_n in cycle t+1 reflect index, guard, active[index] and digit_en in cycle t.
REQ-020 an_n SHALL be ~(1<<index) when guard==0 and digit_en[index]==1; otherwise it SHALL be 8'hFF.
REQ-021 seg_n SHALL be the active-low code of active[index]: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex, dp bit 1). Bit 7 SHALL be ~dp.
REQ-022 Two 8-entry buffers {dp,hex} SHALL exist: shadow (written by the port) and active (displayed).
REQ-023 A commit seen while wr_ready==1 SHALL set pending; wr_ready SHALL be ~pending.
REQ-024 A write and a commit in the same cycle SHALL both be accepted; that write SHALL be included in the copy.
REQ-025 A commit while pending SHALL be ignored.
REQ-026 On a tick with index==7, if pending, all 8 shadow entries SHALL be copied to active in one cycle and pending SHALL clear; the next cycle shows the new digit 0.
REQ-027 frame_done SHALL be registered and SHALL pulse high for exactly one cycle, the cycle after a tick with index==7.
REQ-028 digit_en changes SHALL take effect within one cycle and SHALL NOT affect the scan timing.

Reset
REQ-029 While reset is high: prescaler=0, index=0, guard=BLANK_CYC, pending=0, shadow and active all {0,0}, an_n=8'hFF, seg_n=8'hFF, frame_done=0, wr_ready=1.
REQ-030 Reset asserted mid-frame or while pending SHALL discard the pending commit and all buffer contents.
REQ-031 Writes and commits presented during reset SHALL be ignored.

Verification (CLK_DIV=4, BLANK_CYC=1)
REQ-032 Reset release, no writes -> an_n walks FE,FD,...,7F, one digit per 4 cycles with 1 guard cycle of FF; seg_n=C0; frame_done every 32 cycles.
REQ-033 Write addr3=A dp=1, then commit mid-frame -> wr_ready low until the frame end; then digit 3 shows seg_n=08; other digits stay C0.
REQ-034 Write and commit in the same cycle, then a second commit while pending -> a single copy at the boundary; wr_ready high the next cycle.
REQ-035 digit_en=8'hF0 -> an_n=FF during the slots of digits 0..3; frame_done period unchanged at 32 cycles.
REQ-036 Reset pulsed while pending with shadow modified -> after release all digits show C0, wr_ready=1, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Purpose: multiplexed 8-digit seven-segment scan driver with double-buffered digit storage.
// Latency: an_n/seg_n/frame_done are registered and lag the scan state by one cycle.
// Backpressure: wr_ready drops after an accepted commit and rises once the copy lands at the frame boundary.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   wr_valid/wr_ready   - shadow buffer write handshake (wr_addr, wr_data, wr_dp)
//   commit              - request a shadow-to-active copy at the next frame end
//   digit_en            - per-digit enable, 0 keeps that digit dark
//   an_n, seg_n         - active-low anode selects and {dp,g..a} segments
//   frame_done          - one-cycle pulse after the last digit slot of each frame
module seg7_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [7:0] digit_en,
  output logic [7:0] an_n,
  output logic [7:0] seg_n,
  output logic       frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int GW = $clog2(BLANK_CYC + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(BLANK_CYC);

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [GW-1:0] guard;
  logic          pending;
  digit_t        shadow [8];
  digit_t        active [8];

  logic          tick;
  logic          frame_end;
  logic          wr_fire;
  logic          commit_fire;
  digit_t        cur;
  logic [7:0]    an_nxt;
  logic [7:0]    seg_nxt;

  // Low seven bits of the active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_code(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wr_ready    = ~pending;
  assign tick        = (presc == PRESC_MAX);
  assign frame_end   = tick && (idx == 3'd7);
  assign wr_fire     = wr_valid && wr_ready;
  assign commit_fire = commit && wr_ready;

  always_comb begin
    cur     = active[idx];
    an_nxt  = 8'hFF;
    if ((guard == '0) && digit_en[idx]) begin
      an_nxt = ~(8'd1 << idx);
    end
    seg_nxt = {~cur.dp, seg_code(cur.hex)};
  end

  // Scan timing: prescaler, digit index and the anode-off guard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 3'd0;
      guard <= GUARD_LOAD;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx   <= idx + 3'd1;
        guard <= GUARD_LOAD;
      end else if (guard != '0) begin
        guard <= guard - GW'(1);
      end
    end
  end

  // Buffers and commit handshake. A write accepted alongside a commit lands in
  // shadow before the copy can happen, so it is always part of that copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_fire) begin
        shadow[wr_addr] <= '{dp: wr_dp, hex: wr_data};
      end
      if (frame_end && pending) begin
        for (int i = 0; i < 8; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end else if (commit_fire) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_n       <= 8'hFF;
      seg_n      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with CLK_DIV=4, BLANK_CYC=1.
// Cycle numbers count rising edges after reset release; outputs sampled on the falling edge.
module tb_seg7_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic [7:0] digit_en;
  logic [7:0] an_n;
  logic [7:0] seg_n;
  logic       frame_done;

  seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .commit     (commit),
    .digit_en   (digit_en),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] den;   // digit_en driven after this sample
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur    = 0;

  task automatic add(input int c, input logic [7:0] d, input logic [7:0] a,
                     input logic [7:0] s, input logic f);
    vec_t v;
    v.cyc = c; v.den = d; v.an = a; v.seg = s; v.fd = f;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cur, act, exp);
  endtask

  // Advance to the falling edge inside cycle c.
  task automatic goto(input int c);
    while (cur < c) begin
      @(posedge clk);
      cur++;
    end
    @(negedge clk);
  endtask

  task automatic chk_disp(input logic [7:0] a, input logic [7:0] s);
    chk("an_n", an_n, a);
    chk("seg_n", seg_n, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cur);
    $fatal(1);
  end

  initial begin
    // Reset with a write and commit presented; both must be ignored.
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 3'd0;
    wr_data  = 4'hF;
    wr_dp    = 1'b1;
    commit   = 1'b1;
    digit_en = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);
    chk("rst_rdy", {7'd0, wr_ready}, 8'd1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    commit   = 1'b0;
    cur      = 0;

    // Free-running scan, then digit_en=F0 for one frame.
    add(0,  8'hFF, 8'hFF, 8'hFF, 1'b0);
    add(1,  8'hFF, 8'hFF, 8'hC0, 1'b0);
    add(2,  8'hFF, 8'hFE, 8'hC0, 1'b0);
    add(4,  8'hFF, 8'hFE, 8'hC0, 1'b0);
    add(5,  8'hFF, 8'hFF, 8'hC0, 1'b0);
    add(6,  8'hFF, 8'hFD, 8'hC0, 1'b0);
    add(10, 8'hFF, 8'hFB, 8'hC0, 1'b0);
    add(14, 8'hFF, 8'hF7, 8'hC0, 1'b0);
    add(18, 8'hFF, 8'hEF, 8'hC0, 1'b0);
    add(22, 8'hFF, 8'hDF, 8'hC0, 1'b0);
    add(26, 8'hFF, 8'hBF, 8'hC0, 1'b0);
    add(29, 8'hFF, 8'hFF, 8'hC0, 1'b0);
    add(30, 8'hFF, 8'h7F, 8'hC0, 1'b0);
    add(31, 8'hFF, 8'h7F, 8'hC0, 1'b0);
    add(32, 8'hFF, 8'h7F, 8'hC0, 1'b1);
    add(33, 8'hFF, 8'hFF, 8'hC0, 1'b0);
    add(34, 8'hFF, 8'hFE, 8'hC0, 1'b0);
    add(63, 8'hFF, 8'h7F, 8'hC0, 1'b0);
    add(64, 8'hF0, 8'h7F, 8'hC0, 1'b1);
    add(65, 8'hF0, 8'hFF, 8'hC0, 1'b0);
    add(66, 8'hF0, 8'hFF, 8'hC0, 1'b0);
    add(70, 8'hF0, 8'hFF, 8'hC0, 1'b0);
    add(74, 8'hF0, 8'hFF, 8'hC0, 1'b0);
    add(78, 8'hF0, 8'hFF, 8'hC0, 1'b0);
    add(82, 8'hF0, 8'hEF, 8'hC0, 1'b0);
    add(86, 8'hF0, 8'hDF, 8'hC0, 1'b0);
    add(90, 8'hF0, 8'hBF, 8'hC0, 1'b0);
    add(94, 8'hF0, 8'h7F, 8'hC0, 1'b0);
    add(95, 8'hF0, 8'h7F, 8'hC0, 1'b0);
    add(96, 8'hFF, 8'h7F, 8'hC0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      goto(tbl[i].cyc);
      chk("tbl_an", an_n, tbl[i].an);
      chk("tbl_seg", seg_n, tbl[i].seg);
      chk("tbl_fd", {7'd0, frame_done}, {7'd0, tbl[i].fd});
      digit_en = tbl[i].den;
    end

    // Write digit 3 = A with dp, commit mid-frame; visible only next frame.
    goto(100);
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; wr_dp = 1'b1;
    goto(101);
    chk("b_rdy_pre", {7'd0, wr_ready}, 8'd1);
    wr_valid = 1'b0; commit = 1'b1;
    goto(102);
    commit = 1'b0;
    chk("b_rdy_pend", {7'd0, wr_ready}, 8'd0);
    goto(110);
    chk_disp(8'hF7, 8'hC0);
    goto(127);
    chk("b_rdy_last", {7'd0, wr_ready}, 8'd0);
    goto(128);
    chk("b_rdy_free", {7'd0, wr_ready}, 8'd1);
    chk("b_fd", {7'd0, frame_done}, 8'd1);
    goto(142);
    chk_disp(8'hF7, 8'h08);
    goto(146);
    chk_disp(8'hEF, 8'hC0);

    // Write+commit together, then a commit and write while pending.
    goto(150);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h8; wr_dp = 1'b0; commit = 1'b1;
    goto(151);
    chk("c_rdy_pend", {7'd0, wr_ready}, 8'd0);
    wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 4'h1; commit = 1'b1;
    goto(152);
    wr_valid = 1'b0; commit = 1'b0;
    goto(159);
    chk("c_rdy_last", {7'd0, wr_ready}, 8'd0);
    goto(160);
    chk("c_rdy_free", {7'd0, wr_ready}, 8'd1);
    chk_disp(8'h7F, 8'hC0);
    goto(161);
    chk("c_rdy_after", {7'd0, wr_ready}, 8'd1);
    chk_disp(8'hFF, 8'h80);
    goto(162);
    chk_disp(8'hFE, 8'h80);
    goto(174);
    chk_disp(8'hF7, 8'h08);
    goto(186);
    chk_disp(8'hBF, 8'hC0);

    // Reset while pending, with a write and commit presented during reset.
    goto(193);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'h5; wr_dp = 1'b0; commit = 1'b1;
    goto(194);
    wr_valid = 1'b0; commit = 1'b0;
    chk("d_rdy_pend", {7'd0, wr_ready}, 8'd0);
    goto(195);
    reset = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'h9; wr_dp = 1'b1; commit = 1'b1;
    goto(196);
    chk_disp(8'hFF, 8'hFF);
    chk("d_rst_fd", {7'd0, frame_done}, 8'd0);
    chk("d_rst_rdy", {7'd0, wr_ready}, 8'd1);
    goto(197);
    reset = 1'b0; wr_valid = 1'b0; commit = 1'b0;
    goto(198);
    chk_disp(8'hFF, 8'hC0);
    chk("d_rdy", {7'd0, wr_ready}, 8'd1);
    goto(199);
    chk_disp(8'hFE, 8'hC0);
    goto(207);
    chk_disp(8'hFB, 8'hC0);
    goto(211);
    chk_disp(8'hF7, 8'hC0);
    goto(229);
    chk("d_fd", {7'd0, frame_done}, 8'd1);
    chk("d_an_last", an_n, 8'h7F);
    goto(235);
    chk_disp(8'hFD, 8'hC0);
    goto(240);
    chk_disp(8'hFB, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
